// File: rtl/spi_cmd_ctrl_pkg.sv
// Shared definitions for the SPI command scheduler: command opcodes, frame
// field widths, status flag bit positions, FSM state encoding and the packed
// frame layout used by the queue and the working/response registers.
package spi_cmd_ctrl_pkg;

  localparam int CMD_BITS           = 8;
  localparam int ADDR_BITS          = 8;
  localparam int PAYLOAD_BITS       = 8;
  localparam int MASTER_FRAME_WIDTH = CMD_BITS + ADDR_BITS + PAYLOAD_BITS;

  localparam logic [CMD_BITS-1:0] CMD_LED_SET = 8'h01;
  localparam logic [CMD_BITS-1:0] CMD_LED_GET = 8'h02;
  localparam logic [CMD_BITS-1:0] CMD_STATUS  = 8'h03;

  // Bit positions inside o_status
  localparam int STAT_OVERFLOW = 0;
  localparam int STAT_BAD_ADDR = 1;
  localparam int STAT_TIMEOUT  = 2;
  localparam int STAT_BAD_CMD  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_RESP   = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic [CMD_BITS-1:0]     cmd;
    logic [ADDR_BITS-1:0]    addr;
    logic [PAYLOAD_BITS-1:0] payload;
  } frame_t;

endpackage

// File: rtl/spi_cmd_fifo.sv
// Synchronous command FIFO. A push into a full FIFO is accepted only when a
// pop happens in the same cycle; the head entry is presented combinationally.
// Ports: clk, rst_n (async active-low), push/wdata, pop/rdata, full, empty.
module spi_cmd_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);
  assign rdata     = mem_r[rd_ptr_r];

  // Storage array write port
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Command scheduler between the SPI slave receive side and the register bus.
// Frames are queued, then decoded and dispatched one at a time; read and
// status responses are loaded into the slave transmit frame while cs is high.
// Ports: sysclk, rst_n, rx_dv/i_cmd/i_addr/i_payload (frame in), cs,
//   o_slv_tx_enb/o_slv_frame (slave tx), o_bus_req/we/addr/wdata,
//   i_bus_ack/i_bus_rdata (register bus), o_busy, o_status (sticky flags).
// Optional feature: define SPI_CTRL_TIMEOUT_EN to abandon a bus access after
//   BUS_TIMEOUT cycles without ack (reads then return 8'hFF).
module spi_cmd_ctrl
  import spi_cmd_ctrl_pkg::*;
#(
  parameter int NUM_LEDS    = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic        rx_dv,
  input  logic [7:0]  i_cmd,
  input  logic [7:0]  i_addr,
  input  logic [7:0]  i_payload,
  input  logic        cs,
  output logic        o_slv_tx_enb,
  output logic [23:0] o_slv_frame,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [7:0]  o_bus_addr,
  output logic [7:0]  o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic [7:0]  i_bus_rdata,
  output logic        o_busy,
  output logic [7:0]  o_status
);

  localparam logic [ADDR_BITS-1:0] NUM_LEDS_B = ADDR_BITS'(NUM_LEDS);

  ctrl_state_t state_r;
  frame_t      work_r;
  frame_t      resp_r;
  frame_t      fifo_rdata_s;
  logic [3:0]  flags_r;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic        pop_s;
  logic        ovf_evt_s;
  logic        addr_ok_s;
  logic        status_clr_s;
`ifdef SPI_CTRL_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(BUS_TIMEOUT - 1);
  logic [15:0] to_cnt_r;
`endif

  assign pop_s        = (state_r == ST_IDLE) && !fifo_empty_s;
  // Overflow only when the full queue is not draining in the same cycle
  assign ovf_evt_s    = rx_dv && fifo_full_s && !pop_s;
  assign addr_ok_s    = (work_r.addr < NUM_LEDS_B);
  assign status_clr_s = (state_r == ST_DECODE) && (work_r.cmd == CMD_STATUS);
  assign o_status     = {4'b0000, flags_r};
  assign o_busy       = !fifo_empty_s || (state_r != ST_IDLE);

  spi_cmd_fifo #(
    .WIDTH (MASTER_FRAME_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sysclk),
    .rst_n (rst_n),
    .push  (rx_dv),
    .wdata ({i_cmd, i_addr, i_payload}),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Control FSM with registered bus/slave outputs and sticky status flags
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      work_r       <= '{8'h00, 8'h00, 8'h00};
      resp_r       <= '{8'h00, 8'h00, 8'h00};
      flags_r      <= 4'h0;
      o_bus_req    <= 1'b0;
      o_bus_we     <= 1'b0;
      o_bus_addr   <= 8'h00;
      o_bus_wdata  <= 8'h00;
      o_slv_tx_enb <= 1'b0;
      o_slv_frame  <= 24'h000000;
`ifdef SPI_CTRL_TIMEOUT_EN
      to_cnt_r     <= 16'h0000;
`endif
    end else begin
      // Clear first so flag events later in this block take priority
      if (status_clr_s) begin
        flags_r <= 4'h0;
      end
`ifdef SPI_CTRL_TIMEOUT_EN
      if (state_r != ST_ISSUE) begin
        to_cnt_r <= 16'h0000;
      end
`endif
      case (state_r)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            work_r  <= fifo_rdata_s;
            state_r <= ST_DECODE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_DECODE: begin
          case (work_r.cmd)
            CMD_LED_SET, CMD_LED_GET: begin
              if (addr_ok_s) begin
                o_bus_req   <= 1'b1;
                o_bus_we    <= (work_r.cmd == CMD_LED_SET);
                o_bus_addr  <= work_r.addr;
                o_bus_wdata <= (work_r.cmd == CMD_LED_SET) ? work_r.payload : 8'h00;
                state_r     <= ST_ISSUE;
              end else begin
                flags_r[STAT_BAD_ADDR] <= 1'b1;
                state_r                <= ST_IDLE;
              end
            end
            CMD_STATUS: begin
              resp_r  <= '{work_r.cmd, work_r.addr, o_status};
              state_r <= ST_RESP;
            end
            default: begin
              flags_r[STAT_BAD_CMD] <= 1'b1;
              state_r               <= ST_IDLE;
            end
          endcase
        end
        ST_ISSUE: begin
          // Ack beats a simultaneous timeout expiry
          if (i_bus_ack) begin
            o_bus_req <= 1'b0;
            if (o_bus_we) begin
              state_r <= ST_IDLE;
            end else begin
              resp_r  <= '{work_r.cmd, work_r.addr, i_bus_rdata};
              state_r <= ST_RESP;
            end
`ifdef SPI_CTRL_TIMEOUT_EN
          end else if (to_cnt_r == TO_LAST) begin
            o_bus_req             <= 1'b0;
            flags_r[STAT_TIMEOUT] <= 1'b1;
            if (o_bus_we) begin
              state_r <= ST_IDLE;
            end else begin
              resp_r  <= '{work_r.cmd, work_r.addr, 8'hFF};
              state_r <= ST_RESP;
            end
          end else begin
            to_cnt_r <= to_cnt_r + 16'h0001;
            state_r  <= ST_ISSUE;
          end
`else
          end else begin
            state_r <= ST_ISSUE;
          end
`endif
        end
        ST_RESP: begin
          // Only touch the tx frame while no SPI transaction is in flight
          if (cs) begin
            o_slv_frame  <= resp_r;
            o_slv_tx_enb <= 1'b1;
            state_r      <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
      if (ovf_evt_s) begin
        flags_r[STAT_OVERFLOW] <= 1'b1;
      end
    end
  end

endmodule
